// File: rtl/bit_op_sequencer.sv
// Shift/rotate/bit-invert sequencer: one bit per clock in RUN, result and flags load on entry to DONE.
// Latency: N+1 cycles for shift/rotate count N>=1, 1 cycle otherwise. `start` is ignored while busy.
// Optional BIT_SEQ_ROTATE_CARRY_EN: ROL/ROR rotate through the carry flag as a WORD_SIZE+1 ring.
module bit_op_sequencer #(
    parameter int WORD_SIZE = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WORD_SIZE-1:0] operand,
    input  logic [CNT_W-1:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero_flag,
    output logic                 carry_flag,
    output logic                 overflow_flag
);

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_ROL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_INV  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam int MSB = WORD_SIZE - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [WORD_SIZE-1:0] work, work_nxt;
    logic [CNT_W-1:0]     remaining, remaining_nxt;
    logic [2:0]           op_q, op_nxt;
    logic                 carry_q, carry_nxt;
    logic                 ovf_q, ovf_nxt;

    logic [WORD_SIZE-1:0] step_w;
    logic                 step_c;
    logic                 step_v;

    logic                 load_res;
    logic [WORD_SIZE-1:0] res_w;
    logic                 res_c;
    logic                 res_v;
    logic [WORD_SIZE-1:0] inv_mask;

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    // Shifting past the top bit leaves an all-zero mask, so INV passes the operand through.
    assign inv_mask = {{(WORD_SIZE-1){1'b0}}, 1'b1} << count;

    // One-bit step of the working register.
    always_comb begin
        step_w = work;
        step_c = carry_q;
        step_v = ovf_q;
        case (op_q)
            OP_SHL: begin
                step_w = {work[MSB-1:0], 1'b0};
                step_c = work[MSB];
                step_v = ovf_q | (work[MSB] ^ work[MSB-1]);
            end
            OP_SHR: begin
                step_w = {1'b0, work[MSB:1]};
                step_c = work[0];
            end
            OP_ROL: begin
`ifdef BIT_SEQ_ROTATE_CARRY_EN
                step_w = {work[MSB-1:0], carry_q};
`else
                step_w = {work[MSB-1:0], work[MSB]};
`endif
                step_c = work[MSB];
            end
            OP_ROR: begin
`ifdef BIT_SEQ_ROTATE_CARRY_EN
                step_w = {carry_q, work[MSB:1]};
`else
                step_w = {work[0], work[MSB:1]};
`endif
                step_c = work[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        remaining_nxt = remaining;
        op_nxt        = op_q;
        carry_nxt     = carry_q;
        ovf_nxt       = ovf_q;
        load_res      = 1'b0;
        res_w         = result;
        res_c         = 1'b0;
        res_v         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt        = op;
                    work_nxt      = operand;
                    remaining_nxt = count;
                    ovf_nxt       = 1'b0;
`ifdef BIT_SEQ_ROTATE_CARRY_EN
                    carry_nxt     = carry_flag;
`else
                    carry_nxt     = 1'b0;
`endif
                    if (!op[2] && (count != '0)) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                        load_res  = 1'b1;
                        res_w     = (op == OP_INV) ? (operand ^ inv_mask) : operand;
                    end
                end
            end
            RUN: begin
                work_nxt      = step_w;
                carry_nxt     = step_c;
                ovf_nxt       = step_v;
                remaining_nxt = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                    state_nxt = DONE;
                    load_res  = 1'b1;
                    res_w     = step_w;
                    res_c     = step_c;
                    res_v     = step_v;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            work          <= '0;
            remaining     <= '0;
            op_q          <= OP_PASS;
            carry_q       <= 1'b0;
            ovf_q         <= 1'b0;
            result        <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            remaining <= remaining_nxt;
            op_q      <= op_nxt;
            carry_q   <= carry_nxt;
            ovf_q     <= ovf_nxt;
            if (load_res) begin
                result        <= res_w;
                zero_flag     <= (res_w == '0);
                carry_flag    <= res_c;
                overflow_flag <= res_v;
            end
        end
    end

endmodule

// File: tb/tb_bit_op_sequencer.sv
// Scoreboard bench for bit_op_sequencer: expectations queued at start, checked on each done pulse.
module tb_bit_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] operand;
    logic [3:0] count;
    logic       busy, done, zero_flag, carry_flag, overflow_flag;
    logic [7:0] result;

    bit_op_sequencer #(.WORD_SIZE(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .operand(operand),
        .count(count), .busy(busy), .done(done), .result(result),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        bit         z, c, v;
        int         due;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   model_carry = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [3:0] n,
                                  input bit cin, output logic [7:0] r, output bit c,
                                  output bit v, output int lat);
        logic [31:0] wide;
        logic [7:0]  t;
        bit          cc, nb;
        r = a; c = 1'b0; v = 1'b0; lat = 1;
        if (o[2] == 1'b0 && n != 0) begin
            lat = int'(n) + 1;
            if (o == 3'd0) begin
                wide = {24'b0, a} << n;
                r = wide[7:0];
                c = wide[8];
                for (int k = 0; k < int'(n); k++) begin
                    t = a << k;
                    v = v | (t[7] ^ t[6]);
                end
            end else if (o == 3'd1) begin
                wide = {a, 24'b0} >> n;
                r = wide[31:24];
                c = wide[23];
            end else begin
`ifdef BIT_SEQ_ROTATE_CARRY_EN
                cc = cin;
`else
                cc = 1'b0;
`endif
                for (int k = 0; k < int'(n); k++) begin
                    if (o == 3'd2) begin
`ifdef BIT_SEQ_ROTATE_CARRY_EN
                        nb = cc;
`else
                        nb = r[7];
`endif
                        cc = r[7];
                        r = {r[6:0], nb};
                    end else begin
`ifdef BIT_SEQ_ROTATE_CARRY_EN
                        nb = cc;
`else
                        nb = r[0];
`endif
                        cc = r[0];
                        r = {nb, r[7:1]};
                    end
                end
                c = cc;
            end
        end else if (o == 3'd4) begin
            r = (n < 8) ? (a ^ (8'h01 << n)) : a;
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_result"},   {24'b0, result}, {24'b0, e.r});
                check({e.tag, "_zero"},     {31'b0, zero_flag}, {31'b0, e.z});
                check({e.tag, "_carry"},    {31'b0, carry_flag}, {31'b0, e.c});
                check({e.tag, "_overflow"}, {31'b0, overflow_flag}, {31'b0, e.v});
                check({e.tag, "_latency"},  cyc, e.due);
            end
        end
    end

    task automatic run_cmd(input logic [2:0] o, input logic [7:0] a, input logic [3:0] n,
                           input bit poke, input string tag);
        exp_t x;
        int   lat;
        model(o, a, n, model_carry, x.r, x.c, x.v, lat);
        x.z   = (x.r == 8'h00);
        x.due = cyc + lat;
        x.tag = tag;
        sb.push_back(x);
        model_carry = x.c;
        op = o; operand = a; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); operand = 8'($urandom); count = 4'($urandom);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b1; op = 3'b101; operand = 8'h11; count = 4'd0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; op = 3'b000; operand = 8'h81; count = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_busy",     {31'b0, busy}, 32'd0);
        check("rst_done",     {31'b0, done}, 32'd0);
        check("rst_result",   {24'b0, result}, 32'd0);
        check("rst_zero",     {31'b0, zero_flag}, 32'd0);
        check("rst_carry",    {31'b0, carry_flag}, 32'd0);
        check("rst_overflow", {31'b0, overflow_flag}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_cmd(3'b000, 8'h81, 4'd1, 1'b0, "shl_ovf");
        run_cmd(3'b001, 8'h01, 4'd1, 1'b0, "shr_zero");
        run_cmd(3'b101, 8'h3C, 4'd0, 1'b0, "pass");
        run_cmd(3'b010, 8'h81, 4'd3, 1'b0, "rol3");
        run_cmd(3'b100, 8'h00, 4'd7, 1'b0, "inv7");
        run_cmd(3'b100, 8'h00, 4'd9, 1'b0, "inv9");
        run_cmd(3'b000, 8'h55, 4'd0, 1'b0, "shl_cnt0");
        run_cmd(3'b000, 8'hFF, 4'd10, 1'b0, "shl_drain");
        run_cmd(3'b011, 8'h01, 4'd1, 1'b0, "ror1");
        run_cmd(3'b111, 8'hA5, 4'd3, 1'b0, "op111");
        run_cmd(3'b001, 8'hF4, 4'd3, 1'b1, "shr_poke");
        for (int i = 0; i < 12; i++) begin
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom), 1'b0, "rand");
        end

        op = 3'b001; operand = 8'hF0; count = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b101;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_carry = 1'b0;
        check("midrun_rst_busy",     {31'b0, busy}, 32'd0);
        check("midrun_rst_result",   {24'b0, result}, 32'd0);
        check("midrun_rst_zero",     {31'b0, zero_flag}, 32'd0);
        check("midrun_rst_carry",    {31'b0, carry_flag}, 32'd0);
        check("midrun_rst_overflow", {31'b0, overflow_flag}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        run_cmd(3'b010, 8'h81, 4'd3, 1'b0, "rol3_after_rst");
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_op_sequencer.md
# bit_op_sequencer

Multi-cycle sequencer for the bit-manipulation datapath. It accepts one shift, rotate or bit-invert command per transaction and runs shift/rotate ops one bit per clock for a programmable count. It then registers the result with the zero, carry and overflow flags and reports completion with a one-cycle `done` pulse. It sits between instruction decode and the flag register, and owns all multi-bit shift/rotate sequencing in the processor.

## Interface
- `WORD_SIZE`, 8, operand/result width in bits.
- `CNT_W`, 4, width of `count`. Allows up to 15 steps, or bit positions 0..15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command request; sampled only in IDLE.
- `op`  in  3  000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 INV (toggle bit), 101 PASS; 110/111 treated as PASS.
- `operand`  in  WORD_SIZE  input word; captured when `start` is accepted.
- `count`  in  CNT_W  step count (SHL/SHR/ROL/ROR) or bit position (INV); captured with `operand`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `result` and flags are valid while it is high.
- `result`  out  WORD_SIZE  final word; held until the next `done`.
- `zero_flag`  out  1  `result == 0`.
- `carry_flag`  out  1  last bit shifted or rotated out.
- `overflow_flag`  out  1  SHL only: MSB changed on any step.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE, with `start` high:** capture `operand`, `op` and `count`, and clear the internal overflow accumulator.
  - SHL/SHR/ROL/ROR with `count` ≠ 0: go to RUN with remaining = `count`.
  - All other cases (count 0, INV, PASS): compute the result in the same edge, then go to DONE.
- **IDLE, with `start` low:** stay in IDLE.
- **RUN:** on each edge apply one 1-bit step to the working register and decrement remaining. The edge on which remaining goes from 1 to 0 moves the FSM to DONE.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE on the next edge.
- **SHL:** shifts 0 in at the LSB; carry = outgoing MSB. Overflow is OR-accumulated across steps as `w[MSB] ^ w[MSB-1]` of the pre-step word.
- **SHR:** logical shift, 0 in at the MSB; carry = outgoing LSB; overflow = 0.
- **ROL/ROR:** 8-bit rotate; carry = the bit wrapped on the final step; overflow = 0.
- **Count of 8..15 on shifts:** result 0x00. Carry is the last bit out, so it is 0 once the word has drained.
- **INV:** `result = operand ^ (1 << count)` for count < WORD_SIZE. For count ≥ WORD_SIZE the operand passes through unchanged. Carry = 0, overflow = 0.
- **PASS:** result = operand; carry = 0; overflow = 0.
- **`start` while `busy`:** ignored and not queued.
- **Operand/count changes during RUN:** no effect; the values captured at `start` are used.
- **Flag update:** `result` and all three flags load together, on the edge that enters DONE. They are not updated otherwise.

## Timing
- **Reset:** `reset` = 1 at an edge forces IDLE with `busy` = 0, `done` = 0, `result` = 0 and all flags = 0. This applies in any state, including mid-RUN, where the operation is abandoned with no `done`.
- **Reset priority:** `reset` takes precedence over a simultaneous `start`.
- **Latency, start edge to `done`:**
  - Shift/rotate with count N ≥ 1: `done` is high in the cycle after edge N+1.
  - Count 0, INV and PASS: `done` is high in the cycle after the start edge (1 cycle).
- **`busy`:** rises the cycle after `start` is accepted and falls in the cycle after `done`.
- **Throughput:** a new `start` is accepted in the first IDLE cycle after DONE. Minimum spacing is 2 cycles for single-step ops.

## Configuration
- **`BIT_SEQ_ROTATE_CARRY_EN` defined:** ROL/ROR rotate through carry as a (WORD_SIZE+1)-bit ring.
  - The ring is {carry, word}, seeded with the current `carry_flag` output at `start`.
  - ROL: the old carry enters the LSB and the MSB becomes the new carry.
  - ROR: the old carry enters the MSB and the LSB becomes the new carry.
- **Macro not defined:** plain WORD_SIZE-bit rotate as described under Operation; the prior carry is ignored.

## Test plan
- **SHL with overflow:** `operand` 0x81, SHL, count 1, start → `done` 2 cycles later; result 0x02, carry 1, overflow 1, zero 0.
- **SHR to zero:** `operand` 0x01, SHR, count 1 → result 0x00, zero 1, carry 1, overflow 0.
- **ROL, count 3:** `operand` 0x81 → `done` 4 cycles after start.
  - Macro undefined: result 0x0C, carry 0.
  - `BIT_SEQ_ROTATE_CARRY_EN` defined, carry 0 at start: result 0x0A, carry 0.
- **INV:** `operand` 0x00, count 7 → result 0x80, `done` in 1 cycle. Then `operand` 0x00, count 9 → result 0x00, zero 1.
- **Count 0:** `operand` 0x55, SHL, count 0 → result 0x55, carry 0, overflow 0, `done` in 1 cycle.
- **Start while busy, then reset:** SHR, count 5, start; pulse `start` again during RUN → ignored. Assert `reset` on the 3rd RUN cycle → next cycle `busy` 0, result 0x00, flags 0, and no `done` pulse.
